// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_abs.sv
// Two's-complement conditional negate: magnitude of a signed value, or sign restore of a result.
// Latency: combinational.
// Backpressure: none.
module mdu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Negate when asked; the most-negative value maps onto itself, which is its unsigned magnitude.
    assign res = neg ? (~val + {{(WIDTH-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit, one bit per cycle; signed ops compiled in by macro MDU_SIGNED_EN.
// Latency: done WIDTH+1 cycles after the capture edge; zero-divisor divides finish 1 cycle after capture.
// Backpressure: start is sampled only in IDLE; requests while busy (including the done cycle) are dropped.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    import mdu_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               dz_r;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   b_mag;
    // Shared work register: {partial product high, multiplier} or {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] p;

    logic               signed_op;
    logic               div_op;
    logic               b_zero;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     sub_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MDU_SIGNED_EN
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
`else
    // Without signed support both signed codes fall back to their unsigned twins.
    assign signed_op = 1'b0;
`endif
    assign div_op = (op != OP_MULTU) && (op != OP_MULT);
    assign b_zero = (src_b == '0);

    // Operand magnitudes taken at capture time.
    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.val(src_a), .neg(signed_op & src_a[WIDTH-1]), .res(a_abs));
    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.val(src_b), .neg(signed_op & src_b[WIDTH-1]), .res(b_abs));

    // Sign restore applied while in FIX; neg flags are always 0 for unsigned ops.
    mdu_abs #(.WIDTH(2*WIDTH)) u_fix_p (.val(p), .neg(neg_res), .res(prod_fix));
    mdu_abs #(.WIDTH(WIDTH)) u_fix_q (.val(p[WIDTH-1:0]), .neg(neg_res), .res(quo_fix));
    mdu_abs #(.WIDTH(WIDTH)) u_fix_r (.val(p[2*WIDTH-1:WIDTH]), .neg(neg_rem), .res(rem_fix));

    // One iteration step: shift-add for multiply, trial subtract for restoring divide.
    always_comb begin
        add_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, b_mag & {WIDTH{p[0]}}};
        shifted = p[2*WIDTH-1:WIDTH-1];
        // Remainder stays below the divisor, so the top bit of the difference is a clean borrow.
        sub_res = shifted - {1'b0, b_mag};
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            dz_r     <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_mag    <= '0;
            p        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        is_div  <= div_op;
                        cnt     <= '0;
                        b_mag   <= b_abs;
                        neg_res <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem <= signed_op & src_a[WIDTH-1];
                        if (div_op && b_zero) begin
                            // Keep the raw dividend; it is returned untouched as the remainder.
                            dz_r  <= 1'b1;
                            p     <= {{WIDTH{1'b0}}, src_a};
                            state <= FIX;
                        end else begin
                            dz_r  <= 1'b0;
                            p     <= {{WIDTH{1'b0}}, a_abs};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        p <= sub_res[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                            : {sub_res[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
                    end else begin
                        p <= {add_sum, p[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= DONE;
                    done  <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (dz_r) begin
                        hi       <= p[WIDTH-1:0];
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi       <= rem_fix;
                        lo       <= quo_fix;
                        div_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
